// File: rtl/noc_serial_receiver_if.sv
// node_port: one direction of a serial NoC link (flit data, tail marker, valid/ready).
interface node_port #(
    parameter int unsigned FLIT_BITS = 32
) ();
    logic                 valid;
    logic                 ready;
    logic [FLIT_BITS-1:0] data;
    logic                 tail;

    // Sender side drives the flit, receiver side drives back-pressure.
    modport master (output valid, output data, output tail, input ready);
    modport slave  (input valid, input data, input tail, output ready);

    // Node-port naming: "up" feeds the link, "down" drains it.
    modport up     (output valid, output data, output tail, input ready);
    modport down   (input valid, input data, input tail, output ready);
endinterface

// File: rtl/noc_serial_receiver.sv
// noc_serial_receiver: reassembles LSB-first flits into a packet, drops the padding and
// double-buffers so one packet can be assembled while the previous one awaits the consumer.
module noc_serial_receiver #(
    parameter int unsigned PACKET_BITS  = 32,
    parameter int unsigned PADDING_BITS = 0,
    parameter int unsigned FLIT_BITS    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    node_port.down                 dn,
    input  logic                   flush,
    output logic [PACKET_BITS-1:0] packet,
    output logic                   valid,
    input  logic                   ready,
    output logic                   err
);
    localparam int unsigned TotalBits = PACKET_BITS + PADDING_BITS;
    localparam int unsigned N_FLITS   = TotalBits / FLIT_BITS;
    localparam int unsigned IdxW      = (N_FLITS > 1) ? $clog2(N_FLITS) : 1;
    localparam int unsigned PosW      = (PACKET_BITS > 1) ? $clog2(PACKET_BITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_FLITS - 1);

    localparam logic [0:0] StRecv  = 1'b0;
    localparam logic [0:0] StStall = 1'b1;

    if ((TotalBits % FLIT_BITS) != 0 || N_FLITS < 1) begin : g_bad_cfg
        $error("PACKET_BITS+PADDING_BITS must be a non-zero multiple of FLIT_BITS");
    end

    logic [0:0]             state_q, state_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [PACKET_BITS-1:0] buf_q, buf_d;
    logic [PACKET_BITS-1:0] packet_q, packet_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

    logic                   dn_ready;
    logic                   accept;
    logic                   is_last;
    logic                   frame_bad;
    logic                   frame_end;
    logic [PACKET_BITS-1:0] buf_merged;
    logic [31:0]            pos;

    // Flit handshake and framing decode for the current slot.
    always_comb begin
        dn_ready  = (state_q == StRecv) && !flush && !rst;
        accept    = dn.valid && dn_ready;
        is_last   = (idx_q == LastIdx);
        frame_bad = accept && (dn.tail != is_last);
        frame_end = accept && is_last && dn.tail;
    end

    assign dn.ready = dn_ready;

    // Assembly buffer with the incoming flit written into slot idx; padding bits fall off the top.
    always_comb begin
        buf_merged = buf_q;
        pos        = '0;
        for (int unsigned b = 0; b < FLIT_BITS; b++) begin
            pos = 32'(idx_q) * FLIT_BITS + b;
            if (pos < PACKET_BITS) begin
                buf_merged[pos[PosW-1:0]] = dn.data[b];
            end
        end
    end

    // Next-state: flush beats everything, then stall release, framing errors, completion, fill.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        buf_d    = buf_q;
        packet_d = packet_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        if (flush) begin
            state_d = StRecv;
            idx_d   = '0;
            valid_d = 1'b0;
        end else begin
            if (valid_q && ready) begin
                valid_d = 1'b0;
            end
            if (state_q == StStall) begin
                // Held packet leaves this cycle, so the completed buffer can take its place.
                if (ready) begin
                    packet_d = buf_q;
                    valid_d  = 1'b1;
                    idx_d    = '0;
                    state_d  = StRecv;
                end
            end else if (frame_bad) begin
                err_d = 1'b1;
                idx_d = '0;
            end else if (frame_end) begin
                if (!valid_q || ready) begin
                    packet_d = buf_merged;
                    valid_d  = 1'b1;
                    idx_d    = '0;
                end else begin
                    buf_d   = buf_merged;
                    state_d = StStall;
                end
            end else if (accept) begin
                buf_d = buf_merged;
                idx_d = idx_q + IdxW'(1);
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StRecv;
            idx_q    <= '0;
            buf_q    <= '0;
            packet_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            buf_q    <= buf_d;
            packet_q <= packet_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign packet = packet_q;
    assign valid  = valid_q;
    assign err    = err_q;
endmodule

// File: tb/tb_noc_serial_receiver.sv
// tb_noc_serial_receiver: directed and random flit streams; expected packets go into a
// scoreboard queue when their final flit is accepted and a monitor pops them on consumption.
module tb_noc_serial_receiver;
    localparam int unsigned PB = 20;
    localparam int unsigned PD = 4;
    localparam int unsigned FB = 8;
    localparam int unsigned NF = (PB + PD) / FB;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          flush = 1'b0;
    logic          ready = 1'b0;
    logic [PB-1:0] packet;
    logic          valid;
    logic          err;

    node_port #(.FLIT_BITS(FB)) dn_if ();

    noc_serial_receiver #(
        .PACKET_BITS (PB),
        .PADDING_BITS(PD),
        .FLIT_BITS   (FB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .dn    (dn_if),
        .flush (flush),
        .packet(packet),
        .valid (valid),
        .ready (ready),
        .err   (err)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_bad = 0;
    int            cyc   = 0;
    logic [PB-1:0] exp_q[$];
    bit            err_due[int];
    bit            ready_auto = 1'b0;
    int            ready_pct  = 100;
    bit            gaps       = 1'b0;
    logic          hold_q     = 1'b0;
    logic [PB-1:0] hold_pkt   = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Random consumer back-pressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_auto) ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Monitor: consumption against scoreboard, hold stability, err pulses.
    always @(negedge clk) begin
        if (rst) begin
            hold_q <= 1'b0;
        end else begin
            if (hold_q) chk("packet_stable", packet, hold_pkt);
            if (valid && ready && !flush) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious_packet: got 0x%0h, required no packet", packet);
                end else begin
                    chk("packet", packet, exp_q.pop_front());
                end
            end
            chk("err", err, err_due.exists(cyc));
            err_due.delete(cyc);
            hold_q   <= valid && !ready && !flush;
            hold_pkt <= packet;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one flit until accepted; record the model's consequences at the accept point.
    task automatic send_flit(input logic [FB-1:0] d, input logic t, input bit push,
                             input logic [PB-1:0] pkt, input bit bad);
        int budget;
        budget      = 500;
        dn_if.valid = 1'b1;
        dn_if.data  = d;
        dn_if.tail  = t;
        forever begin
            @(negedge clk);
            if (dn_if.ready) begin
                if (push) exp_q.push_back(pkt);
                if (bad) err_due[cyc + 1] = 1'b1;
                break;
            end
            budget--;
            if (budget == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL flit_accept_timeout: dn.ready 0 for 500 cycles, required 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        dn_if.valid = 1'b0;
    endtask

    task automatic do_flush();
        flush       = 1'b1;
        dn_if.valid = 1'b0;
        @(negedge clk);
        exp_q.delete();
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    // kind: 0 good, 1 early tail on flit cut, 2 missing tail, 3 flush before flit cut.
    task automatic send_packet(input logic [PB-1:0] pkt, input logic [PD-1:0] pad,
                               input int kind, input int cut);
        logic [NF*FB-1:0] full;
        logic [FB-1:0]    f;
        full = {pad, pkt};
        for (int k = 0; k < int'(NF); k++) begin
            f = full[k*FB +: FB];
            if (gaps) idle(int'($urandom_range(2)));
            if (kind == 3 && k == cut) begin
                do_flush();
                return;
            end
            if (kind == 1 && k == cut) begin
                send_flit(f, 1'b1, 1'b0, pkt, 1'b1);
                return;
            end
            if (k == int'(NF) - 1) send_flit(f, kind == 0, kind == 0, pkt, kind == 2);
            else send_flit(f, 1'b0, 1'b0, pkt, 1'b0);
        end
    endtask

    task automatic do_reset();
        dn_if.valid = 1'b0;
        flush       = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_packet", packet, 0);
        chk("rst_err", err, 0);
        chk("rst_dn_ready", dn_if.ready, 0);
        exp_q.delete();
        err_due.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("dn_ready_after_rst", dn_if.ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        dn_if.valid = 1'b0;
        dn_if.data  = '0;
        dn_if.tail  = 1'b0;
        #1;
        chk("init_valid", valid, 0);
        chk("init_packet", packet, 0);
        chk("init_err", err, 0);
        chk("init_dn_ready", dn_if.ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("dn_ready_first", dn_if.ready, 1);
        @(posedge clk);
        #1;

        // Basic packet: 0x45, 0x23, 0xF1 -> 0x12345, padding nibble dropped.
        ready = 1'b1;
        send_packet(20'h12345, 4'hF, 0, 0);
        chk("latency_valid", valid, 1);
        chk("latency_packet", packet, 20'h12345);
        idle(1);
        ready = 1'b0;

        // Hold first packet, assemble second into STALL, then release.
        send_packet(20'h0BEEF, 4'h0, 0, 0);
        send_packet(20'hA5A5A, 4'h3, 0, 0);
        chk("stall_dn_ready", dn_if.ready, 0);
        chk("stall_packet", packet, 20'h0BEEF);
        ready = 1'b1;
        idle(1);
        chk("unstall_valid", valid, 1);
        chk("unstall_packet", packet, 20'hA5A5A);
        chk("unstall_dn_ready", dn_if.ready, 1);
        idle(1);

        // Early tail, recovery, then missing tail.
        send_packet(20'h11111, 4'h0, 1, 1);
        send_packet(20'h12345, 4'h0, 0, 0);
        chk("err_recover", packet, 20'h12345);
        send_packet(20'h32211, 4'h0, 2, 0);
        idle(3);
        chk("no_valid_after_err", valid, 0);

        // Flush with a held packet and a partial one.
        ready = 1'b0;
        send_packet(20'h55555, 4'h0, 0, 0);
        send_packet(20'h66666, 4'h0, 3, 2);
        chk("flush_valid", valid, 0);
        ready = 1'b1;
        send_packet(20'h0ABCD, 4'h0, 0, 0);
        chk("flush_recover", packet, 20'h0ABCD);
        idle(1);

        // Reset mid-packet with a valid packet held.
        ready = 1'b0;
        send_packet(20'h77777, 4'h0, 0, 0);
        send_flit(8'h88, 1'b0, 1'b0, '0, 1'b0);
        send_flit(8'h88, 1'b0, 1'b0, '0, 1'b0);
        do_reset();
        ready = 1'b1;
        send_packet(20'h13579, 4'h2, 0, 0);
        chk("reset_recover", packet, 20'h13579);
        idle(1);

        // Random traffic.
        ready_auto = 1'b1;
        gaps       = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int r;
            int kind;
            int cut;
            if (i % 50 == 0) ready_pct = (i % 100 == 0) ? 100 : int'($urandom_range(10, 60));
            r    = int'($urandom_range(99));
            kind = (r < 78) ? 0 : (r < 86) ? 1 : (r < 94) ? 2 : 3;
            cut  = (kind == 1) ? int'($urandom_range(NF - 2)) : int'($urandom_range(NF - 1));
            send_packet(PB'($urandom), PD'($urandom), kind, cut);
        end

        // Drain everything still pending.
        gaps       = 1'b0;
        ready_auto = 1'b0;
        ready      = 1'b1;
        idle(6);
        chk("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
